// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default framing constants, idle line level.
// Used by both the transmitter and the receiver.
package uart_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] ST_START  = 3'd1;
    localparam logic [STATE_W-1:0] ST_DATA   = 3'd2;
    localparam logic [STATE_W-1:0] ST_PARITY = 3'd3;
    localparam logic [STATE_W-1:0] ST_STOP   = 3'd4;

    // 100 MHz system clock at 9600 baud
    localparam int UART_CLKS_PER_BIT = 10417;
    localparam int UART_DATA_BITS    = 8;

    localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/uart_tx_if.sv
// Request/status handshake between a byte source and the UART transmitter.
interface uart_tx_if #(
    parameter int DATA_BITS = uart_pkg::UART_DATA_BITS
) ();

    logic                 tx_start;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_busy;
    logic                 tx_done;

    modport master (
        output tx_start,
        output tx_data,
        input  tx_busy,
        input  tx_done
    );

    modport slave (
        input  tx_start,
        input  tx_data,
        output tx_busy,
        output tx_done
    );

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the last cycle
// of each period with a registered one-cycle bit_end pulse.
import uart_pkg::*;

module uart_baud_gen #(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic bit_end
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_next_s;
    logic             bit_end_r;

    // Next count value with wrap at the bit boundary
    always_comb begin
        count_next_s = count_r;
        if (count_r == LAST) begin
            count_next_s = {CNT_W{1'b0}};
        end else begin
            count_next_s = count_r + CNT_W'(1);
        end
    end

    // bit_end is registered one cycle early so it coincides with count == LAST
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r   <= {CNT_W{1'b0}};
            bit_end_r <= 1'b0;
        end else if (clear) begin
            count_r   <= {CNT_W{1'b0}};
            bit_end_r <= 1'b0;
        end else if (enable) begin
            count_r   <= count_next_s;
            bit_end_r <= (count_next_s == LAST);
        end else begin
            bit_end_r <= 1'b0;
        end
    end

    assign bit_end = bit_end_r;

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first, internal baud divider.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
import uart_pkg::*;

module uart_tx #(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int DATA_BITS    = UART_DATA_BITS
) (
    input  logic      clk,
    input  logic      rst_n,
    uart_tx_if.slave  bus,
    output logic      tx
);

    localparam int BIT_CNT_W = $clog2(DATA_BITS + 1);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_BITS - 1);

    logic [STATE_W-1:0]   state_r;
    logic [DATA_BITS-1:0] shift_r;
    logic [DATA_BITS-1:0] shift_next_s;
    logic [BIT_CNT_W-1:0] bit_cnt_r;
    logic                 tx_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 baud_clear_s;
    logic                 bit_end_s;

`ifdef UART_TX_PARITY_EN
    logic                 parity_r;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction
`endif

    assign baud_clear_s = (state_r == ST_IDLE);
    assign shift_next_s = shift_r >> 1;

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (baud_clear_s),
        .enable  (!baud_clear_s),
        .bit_end (bit_end_s)
    );

    // Frame sequencer; tx only changes on acceptance or on a bit boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            shift_r   <= {DATA_BITS{1'b0}};
            bit_cnt_r <= {BIT_CNT_W{1'b0}};
            tx_r      <= LINE_IDLE;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_r  <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    tx_r <= LINE_IDLE;
                    if (bus.tx_start) begin
                        shift_r  <= bus.tx_data;
                        state_r  <= ST_START;
                        tx_r     <= 1'b0;
                        busy_r   <= 1'b1;
`ifdef UART_TX_PARITY_EN
                        parity_r <= even_parity(bus.tx_data);
`endif
                    end
                end
                ST_START: begin
                    if (bit_end_s) begin
                        state_r   <= ST_DATA;
                        tx_r      <= shift_r[0];
                        bit_cnt_r <= {BIT_CNT_W{1'b0}};
                    end
                end
                ST_DATA: begin
                    if (bit_end_s) begin
                        if (bit_cnt_r == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                            state_r <= ST_PARITY;
                            tx_r    <= parity_r;
`else
                            state_r <= ST_STOP;
                            tx_r    <= LINE_IDLE;
`endif
                        end else begin
                            shift_r   <= shift_next_s;
                            tx_r      <= shift_next_s[0];
                            bit_cnt_r <= bit_cnt_r + BIT_CNT_W'(1);
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (bit_end_s) begin
                        state_r <= ST_STOP;
                        tx_r    <= LINE_IDLE;
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_end_s) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    tx_r    <= LINE_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign tx          = tx_r;
    assign bus.tx_busy = busy_r;
    assign bus.tx_done = done_r;

endmodule
